// File: rtl/result_frame_tx.sv
// Buffers encrypted result bytes and returns them as one UART frame: length, payload, optional checksum.
// Optional feature: define FRAME_CHECKSUM_EN to append an XOR checksum byte over the payload.
module result_frame_tx #(
   parameter int unsigned MAX_BYTES = 100,
   parameter int unsigned IDX_W     = 8
) (
   input  logic             Clk_100M,
   input  logic             Reset,
   input  logic [7:0]       In_Data,
   input  logic             In_Valid,
   input  logic             In_Last,
   output logic             In_Ready,
   output logic [7:0]       Tx_Data,
   output logic             Tx_Send,
   input  logic             Tx_Busy,
   output logic             Frame_Busy,
   output logic             Frame_Done,
   output logic             Overflow
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned BUF_AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_BYTES - 1);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      LOAD    = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } txState_t;

   txState_t state;
   txState_t stateNxt;

   logic [BYTE_W-1:0] frameBuf [MAX_BYTES];

   logic [IDX_W-1:0]  wrIdx;
   logic [IDX_W-1:0]  wrIdxNxt;
   logic [IDX_W-1:0]  rdIdx;
   logic [IDX_W-1:0]  rdIdxNxt;
   logic              lenSent;
   logic              lenSentNxt;
`ifdef FRAME_CHECKSUM_EN
   logic [BYTE_W-1:0] csum;
   logic [BYTE_W-1:0] csumNxt;
   logic              csumSent;
   logic              csumSentNxt;
`endif

   logic              inReadyNxt;
   logic [BYTE_W-1:0] txDataNxt;
   logic              txSendNxt;
   logic              frameBusyNxt;
   logic              frameDoneNxt;
   logic              overflowNxt;

   logic              accept;
   logic              isFull;
   logic              moreBytes;

   assign accept = In_Valid & In_Ready;
   assign isFull = (wrIdx == LAST_IDX);

   // wrIdx doubles as the frame length once collection has stopped
`ifdef FRAME_CHECKSUM_EN
   assign moreBytes = (rdIdx < wrIdx) || !csumSent;
`else
   assign moreBytes = (rdIdx < wrIdx);
`endif

   // State register
   always_ff @(posedge Clk_100M) begin
      if (!Reset) begin
         state <= COLLECT;
      end else begin
         state <= stateNxt;
      end
   end

   // Next-state logic
   always_comb begin
      stateNxt = state;
      case (state)
         COLLECT: begin
            if (accept && (In_Last || isFull)) begin
               stateNxt = LOAD;
            end
         end
         LOAD: begin
            if (!Tx_Busy) begin
               stateNxt = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (Tx_Busy) begin
               stateNxt = WAIT_LO;
            end
         end
         WAIT_LO: begin
            if (!Tx_Busy) begin
               stateNxt = moreBytes ? LOAD : COLLECT;
            end
         end
         default: stateNxt = COLLECT;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      wrIdxNxt     = wrIdx;
      rdIdxNxt     = rdIdx;
      lenSentNxt   = lenSent;
`ifdef FRAME_CHECKSUM_EN
      csumNxt      = csum;
      csumSentNxt  = csumSent;
`endif
      inReadyNxt   = (stateNxt == COLLECT);
      txDataNxt    = Tx_Data;
      txSendNxt    = 1'b0;
      frameBusyNxt = Frame_Busy;
      frameDoneNxt = 1'b0;
      overflowNxt  = Overflow;

      case (state)
         COLLECT: begin
            if (accept) begin
               wrIdxNxt     = wrIdx + IDX_W'(1);
               frameBusyNxt = 1'b1;
`ifdef FRAME_CHECKSUM_EN
               csumNxt      = csum ^ In_Data;
`endif
               // In_Last wins when the final byte exactly fills the buffer
               if (!In_Last && isFull) begin
                  overflowNxt = 1'b1;
               end
            end
         end
         LOAD: begin
            if (!Tx_Busy) begin
               txSendNxt = 1'b1;
               if (!lenSent) begin
                  txDataNxt  = BYTE_W'(wrIdx);
                  lenSentNxt = 1'b1;
               end else if (rdIdx < wrIdx) begin
                  txDataNxt = frameBuf[BUF_AW'(rdIdx)];
                  rdIdxNxt  = rdIdx + IDX_W'(1);
               end else begin
`ifdef FRAME_CHECKSUM_EN
                  txDataNxt   = csum;
                  csumSentNxt = 1'b1;
`else
                  txDataNxt   = Tx_Data;
`endif
               end
            end
         end
         WAIT_LO: begin
            if (!Tx_Busy && !moreBytes) begin
               frameDoneNxt = 1'b1;
               frameBusyNxt = 1'b0;
               wrIdxNxt     = '0;
               rdIdxNxt     = '0;
               lenSentNxt   = 1'b0;
`ifdef FRAME_CHECKSUM_EN
               csumNxt      = '0;
               csumSentNxt  = 1'b0;
`endif
            end
         end
         default: begin
         end
      endcase
   end

   // Registered outputs and counters
   always_ff @(posedge Clk_100M) begin
      if (!Reset) begin
         wrIdx      <= '0;
         rdIdx      <= '0;
         lenSent    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
         csum       <= '0;
         csumSent   <= 1'b0;
`endif
         In_Ready   <= 1'b1;
         Tx_Data    <= '0;
         Tx_Send    <= 1'b0;
         Frame_Busy <= 1'b0;
         Frame_Done <= 1'b0;
         Overflow   <= 1'b0;
      end else begin
         wrIdx      <= wrIdxNxt;
         rdIdx      <= rdIdxNxt;
         lenSent    <= lenSentNxt;
`ifdef FRAME_CHECKSUM_EN
         csum       <= csumNxt;
         csumSent   <= csumSentNxt;
`endif
         In_Ready   <= inReadyNxt;
         Tx_Data    <= txDataNxt;
         Tx_Send    <= txSendNxt;
         Frame_Busy <= frameBusyNxt;
         Frame_Done <= frameDoneNxt;
         Overflow   <= overflowNxt;
      end
   end

   // Payload storage, no reset needed
   always_ff @(posedge Clk_100M) begin
      if (Reset && accept) begin
         frameBuf[BUF_AW'(wrIdx)] <= In_Data;
      end
   end

endmodule

// File: tb/tb_result_frame_tx.sv
// Bench for result_frame_tx: UART sender model, frame-level reference model, directed and random frames.
module tb_result_frame_tx;

   localparam int MAX_BYTES  = 100;
   localparam int IDX_W      = 8;
   localparam int WAIT_BOUND = 20000;

   typedef logic [7:0] byteQ_t[$];

   logic       Clk_100M = 1'b0;
   logic       Reset;
   logic [7:0] In_Data;
   logic       In_Valid;
   logic       In_Last;
   logic       In_Ready;
   logic [7:0] Tx_Data;
   logic       Tx_Send;
   logic       Tx_Busy;
   logic       Frame_Busy;
   logic       Frame_Done;
   logic       Overflow;

   int testsRun    = 0;
   int testsFailed = 0;

   logic       uartBusy  = 1'b0;
   logic       busyForce = 1'b0;
   int         dlyCnt    = 0;
   int         busyCnt   = 0;
   logic [7:0] txLog[$];
   int         doneCnt   = 0;
   int         wideSend  = 0;
   logic       prevSend  = 1'b0;
   bit         expOvf    = 1'b0;

   assign Tx_Busy = uartBusy | busyForce;

   always #5 Clk_100M = ~Clk_100M;

   result_frame_tx #(
      .MAX_BYTES(MAX_BYTES),
      .IDX_W    (IDX_W)
   ) dut (
      .Clk_100M  (Clk_100M),
      .Reset     (Reset),
      .In_Data   (In_Data),
      .In_Valid  (In_Valid),
      .In_Last   (In_Last),
      .In_Ready  (In_Ready),
      .Tx_Data   (Tx_Data),
      .Tx_Send   (Tx_Send),
      .Tx_Busy   (Tx_Busy),
      .Frame_Busy(Frame_Busy),
      .Frame_Done(Frame_Done),
      .Overflow  (Overflow)
   );

   // UART_Sender model: random start delay, then busy for a random number of cycles
   always @(posedge Clk_100M) begin
      if (!Reset) begin
         dlyCnt   <= 0;
         busyCnt  <= 0;
         uartBusy <= 1'b0;
      end else if (Tx_Send) begin
         dlyCnt  <= int'($urandom_range(2, 0));
         busyCnt <= int'($urandom_range(6, 1));
      end else if (dlyCnt != 0) begin
         dlyCnt <= dlyCnt - 1;
      end else if (busyCnt != 0) begin
         uartBusy <= 1'b1;
         busyCnt  <= busyCnt - 1;
      end else begin
         uartBusy <= 1'b0;
      end
   end

   // Wire monitor: captured bytes, strobe width, done pulses
   always @(posedge Clk_100M) begin
      if (Tx_Send) txLog.push_back(Tx_Data);
      if (Tx_Send && prevSend) wideSend++;
      if (Frame_Done) doneCnt++;
      prevSend = Tx_Send;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: observed no finish, expected finish before 2ms");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk_100M);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] d, input bit last);
      bit ready;
      bit done;
      done = 1'b0;
      repeat ($urandom_range(2, 0)) tick();
      In_Data  = d;
      In_Valid = 1'b1;
      In_Last  = last;
      for (int k = 0; k < WAIT_BOUND && !done; k++) begin
         ready = In_Ready;
         tick();
         done = ready;
      end
      In_Valid = 1'b0;
      In_Last  = 1'b0;
      check("byte_accepted", 32'(done), 1);
   endtask

   task automatic checkResetOutputs(input string pfx);
      check({pfx, "_in_ready"},   32'(In_Ready),   1);
      check({pfx, "_tx_data"},    32'(Tx_Data),    0);
      check({pfx, "_tx_send"},    32'(Tx_Send),    0);
      check({pfx, "_frame_busy"}, 32'(Frame_Busy), 0);
      check({pfx, "_frame_done"}, 32'(Frame_Done), 0);
      check({pfx, "_overflow"},   32'(Overflow),   0);
   endtask

   // Offers bytesQ as one frame and checks the wire image against the frame rules
   task automatic runFrame(input byteQ_t bytesQ, input bit withLast, input int holdCycles);
      byteQ_t     expQ;
      int         n;
      logic [7:0] cs;
      int         doneBefore;
      int         wideBefore;
      bit         seen;
      logic [7:0] obs;
      cs   = 8'h00;
      seen = 1'b0;
      n = (bytesQ.size() > MAX_BYTES) ? MAX_BYTES : bytesQ.size();
      expQ.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
         expQ.push_back(bytesQ[i]);
         cs = cs ^ bytesQ[i];
      end
`ifdef FRAME_CHECKSUM_EN
      expQ.push_back(cs);
`endif
      if (!withLast) expOvf = 1'b1;

      txLog.delete();
      doneBefore = doneCnt;
      wideBefore = wideSend;
      if (holdCycles > 0) busyForce = 1'b1;

      for (int i = 0; i < n; i++) sendByte(bytesQ[i], withLast && (i == n - 1));
      check("busy_after_last", 32'(Frame_Busy), 1);

      if (!withLast) begin
         check("ready_low_when_full", 32'(In_Ready), 0);
         check("overflow_set", 32'(Overflow), 1);
         if (bytesQ.size() > MAX_BYTES) begin
            In_Data  = bytesQ[MAX_BYTES];
            In_Valid = 1'b1;
            repeat (3) begin
               tick();
               check("extra_byte_refused", 32'(In_Ready), 0);
            end
            In_Valid = 1'b0;
         end
      end else if (holdCycles > 0) begin
         repeat (holdCycles) tick();
         check("held_busy_no_send", 32'(txLog.size()), 0);
         check("held_busy_send_low", 32'(Tx_Send), 0);
         busyForce = 1'b0;
      end else begin
         check("latency_cycle1_idle", 32'(Tx_Send), 0);
         tick();
         check("latency_cycle2_send", 32'(Tx_Send), 1);
         check("latency_length_byte", 32'(Tx_Data), 32'(expQ[0]));
      end

      for (int k = 0; k < WAIT_BOUND && !seen; k++) begin
         tick();
         seen = Frame_Done;
      end
      check("frame_done_seen", 32'(seen), 1);
      check("ready_at_done", 32'(In_Ready), 1);
      check("busy_clear_at_done", 32'(Frame_Busy), 0);
      tick();
      check("done_one_cycle", 32'(Frame_Done), 0);
      check("done_pulse_count", 32'(doneCnt - doneBefore), 1);
      check("tx_send_count", 32'(txLog.size()), 32'(expQ.size()));
      for (int i = 0; i < expQ.size(); i++) begin
         obs = (i < txLog.size()) ? txLog[i] : 8'hxx;
         check($sformatf("tx_byte[%0d]", i), 32'(obs), 32'(expQ[i]));
      end
      check("send_one_cycle_wide", 32'(wideSend - wideBefore), 0);
      check("overflow_sticky", 32'(Overflow), 32'(expOvf));
   endtask

   initial begin
      byteQ_t q;
      int     len;
      bit     wl;
      bit     reached;
      int     doneBefore;

      Reset    = 1'b0;
      In_Data  = 8'h00;
      In_Valid = 1'b0;
      In_Last  = 1'b0;
      repeat (3) tick();
      checkResetOutputs("reset");
      Reset = 1'b1;
      tick();

      q = {8'h41, 8'h42, 8'h43};
      runFrame(q, 1'b1, 0);

      q = {8'hFF};
      runFrame(q, 1'b1, 0);

      q.delete();
      repeat (4) q.push_back(8'($urandom));
      runFrame(q, 1'b1, 50);

      q.delete();
      for (int i = 0; i <= 8'h64; i++) q.push_back(8'(i));
      runFrame(q, 1'b0, 0);

      // Abort while the second payload byte is on the wire
      q = {8'h21, 8'h22, 8'h23};
      txLog.delete();
      doneBefore = doneCnt;
      for (int i = 0; i < q.size(); i++) sendByte(q[i], i == q.size() - 1);
      reached = 1'b0;
      for (int k = 0; k < WAIT_BOUND && !reached; k++) begin
         tick();
         reached = (txLog.size() >= 3);
      end
      check("midframe_reached", 32'(reached), 1);
      Reset = 1'b0;
      tick();
      checkResetOutputs("midframe_reset");
      expOvf = 1'b0;
      Reset  = 1'b1;
      txLog.delete();
      repeat (20) tick();
      check("no_send_after_abort", 32'(txLog.size()), 0);
      check("no_done_after_abort", 32'(doneCnt - doneBefore), 0);
      q = {8'h10};
      runFrame(q, 1'b1, 0);

      for (int f = 0; f < 10; f++) begin
         len = int'($urandom_range(110, 1));
         if (len > MAX_BYTES)       wl = 1'b0;
         else if (len == MAX_BYTES) wl = 1'($urandom);
         else                       wl = 1'b1;
         q.delete();
         for (int i = 0; i < len; i++) q.push_back(8'($urandom));
         runFrame(q, wl, 0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
